// File: rtl/elevator_car_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_car_ctrl
// Car-motion and door sequencer for a two-floor elevator (floor 0 = lower,
// floor 1 = upper). Latches hall/car push-button requests and schedules
// service between the two floors. Drives timed motor-up, motor-down and
// door-open phases, and exports floor, state and lamp status.
//
// Parameters
//   DOOR_DWELL : cycles the door is held open per service (>= 1)
//   TRAVEL     : cycles the motor runs for one floor-to-floor trip (>= 1)
//   CNT_W      : phase-timer width, must hold max(DOOR_DWELL, TRAVEL)-1
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   GUPB/GLPB in   ground-panel upper/lower floor request (level)
//   CUPB/CLPB in   car-panel upper/lower floor request (level)
//   floor     out  current car floor
//   motor_up  out  motor up command      (registered)
//   motor_dn  out  motor down command    (registered)
//   door_open out  door open command     (registered)
//   req_lamp  out  latched requests, bit0 = lower, bit1 = upper
//   state     out  00 IDLE, 01 OPEN, 10 MOVE_UP, 11 MOVE_DN
// -----------------------------------------------------------------------------
module elevator_car_ctrl #(
  parameter int unsigned DOOR_DWELL = 8,
  parameter int unsigned TRAVEL     = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       GUPB,
  input  logic       GLPB,
  input  logic       CUPB,
  input  logic       CLPB,
  output logic       floor,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       door_open,
  output logic [1:0] req_lamp,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_OPEN    = 2'b01,
    S_MOVE_UP = 2'b10,
    S_MOVE_DN = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DOOR_DWELL - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic             floor_q, floor_d;
  logic [1:0]       req_q, req_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             motor_up_q, motor_dn_q, door_open_q;

  logic [1:0]       press;
  logic             here;
  logic             there;

  // Button presses folded per floor: bit0 = lower, bit1 = upper.
  assign press = {GUPB | CUPB, GLPB | CLPB};
  assign here  = floor_q;
  assign there = ~floor_q;

  // State, floor, request and timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      floor_q     <= 1'b0;
      req_q       <= 2'b00;
      timer_q     <= CNT_ZERO;
      motor_up_q  <= 1'b0;
      motor_dn_q  <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      req_q       <= req_d;
      timer_q     <= timer_d;
      motor_up_q  <= (state_d == S_MOVE_UP);
      motor_dn_q  <= (state_d == S_MOVE_DN);
      door_open_q <= (state_d == S_OPEN);
    end
  end

  // Next-state, request latching and phase timer.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    req_d   = req_q | press;
    timer_d = timer_q;

    unique case (state_q)
      S_IDLE: begin
        // Decisions use the already-latched requests; current floor wins.
        if (req_q[here]) begin
          state_d     = S_OPEN;
          req_d[here] = 1'b0;
          timer_d     = DWELL_LD;
        end else if (req_q[there]) begin
          state_d = floor_q ? S_MOVE_DN : S_MOVE_UP;
          timer_d = TRAVEL_LD;
        end
      end

      S_OPEN: begin
        // A press for the open floor extends the dwell instead of latching.
        req_d[here] = req_q[here];
        if (press[here]) begin
          timer_d = DWELL_LD;
        end else if (timer_q != CNT_ZERO) begin
          timer_d = timer_q - CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MOVE_UP, S_MOVE_DN: begin
        if (timer_q != CNT_ZERO) begin
          timer_d = timer_q - CNT_ONE;
        end else begin
          // Arrival: the clear of the reached floor beats a same-cycle press.
          floor_d      = there;
          state_d      = S_OPEN;
          req_d[there] = 1'b0;
          timer_d      = DWELL_LD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign floor     = floor_q;
  assign motor_up  = motor_up_q;
  assign motor_dn  = motor_dn_q;
  assign door_open = door_open_q;
  assign req_lamp  = req_q;
  assign state     = state_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_car_ctrl
// Directed scenarios followed by a randomized button phase. Every cycle the
// outputs are compared with a behavioural model that tracks phase and cycles
// remaining in that phase; directed scenarios add constant expectations for
// phase lengths, floors and lamps.
// -----------------------------------------------------------------------------
module tb_elevator_car_ctrl;

  localparam int DWELL  = 8;
  localparam int TRAVEL = 16;

  localparam int S_IDLE = 0;
  localparam int S_OPEN = 1;
  localparam int S_UP   = 2;
  localparam int S_DN   = 3;

  logic       clk;
  logic       reset;
  logic       GUPB, GLPB, CUPB, CLPB;
  logic       floor, motor_up, motor_dn, door_open;
  logic [1:0] req_lamp, state;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: phase, cycles left in that phase, floor, pending calls.
  int     m_st;
  int     m_left;
  bit     m_floor;
  bit [1:0] m_req;

  elevator_car_ctrl #(
    .DOOR_DWELL(DWELL),
    .TRAVEL    (TRAVEL),
    .CNT_W     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .GUPB     (GUPB),
    .GLPB     (GLPB),
    .CUPB     (CUPB),
    .CLPB     (CLPB),
    .floor    (floor),
    .motor_up (motor_up),
    .motor_dn (motor_dn),
    .door_open(door_open),
    .req_lamp (req_lamp),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_st    = S_IDLE;
    m_left  = 0;
    m_floor = 1'b0;
    m_req   = 2'b00;
  endtask

  task automatic model_step(input bit lo, input bit hi);
    bit [1:0] p;
    bit [1:0] old;
    bit       here;
    bit       there;
    p     = {hi, lo};
    old   = m_req;
    here  = m_floor;
    there = !m_floor;
    case (m_st)
      S_IDLE: begin
        m_req = old | p;
        if (old[here]) begin
          m_st        = S_OPEN;
          m_left      = DWELL;
          m_req[here] = 1'b0;
        end else if (old[there]) begin
          m_st   = here ? S_DN : S_UP;
          m_left = TRAVEL;
        end
      end
      S_OPEN: begin
        m_req[there] = old[there] | p[there];
        if (p[here])          m_left = DWELL;
        else if (m_left == 1) m_st   = S_IDLE;
        else                  m_left = m_left - 1;
      end
      default: begin
        m_req = old | p;
        if (m_left == 1) begin
          m_floor      = there;
          m_st         = S_OPEN;
          m_left       = DWELL;
          m_req[there] = 1'b0;
        end else begin
          m_left = m_left - 1;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/state"},     8'(state),     8'(m_st));
    chk({tag, "/floor"},     8'(floor),     8'(m_floor));
    chk({tag, "/req_lamp"},  8'(req_lamp),  8'(m_req));
    chk({tag, "/motor_up"},  8'(motor_up),  8'(m_st == S_UP));
    chk({tag, "/motor_dn"},  8'(motor_dn),  8'(m_st == S_DN));
    chk({tag, "/door_open"}, 8'(door_open), 8'(m_st == S_OPEN));
  endtask

  // One clock: advance the model with the inputs seen at this edge, then compare.
  task automatic tick(input string tag);
    if (reset) model_reset();
    else       model_step(GLPB | CLPB, GUPB | CUPB);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wait_settled(input string tag);
    int n;
    n = 0;
    while (!(m_st == S_IDLE && m_req == 2'b00) && n < 200) begin
      tick(tag);
      n++;
    end
    chk({tag, "/settle_timeout"}, 8'(n < 200), 8'(1));
  endtask

  task automatic release_buttons();
    GUPB = 1'b0; GLPB = 1'b0; CUPB = 1'b0; CLPB = 1'b0;
  endtask

  initial begin
    int cnt;

    // Reset held with every button pressed: outputs must stay cleared.
    reset = 1'b1;
    GUPB = 1'b1; GLPB = 1'b1; CUPB = 1'b1; CLPB = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick("reset");
      chk("reset/all_zero", 8'({floor, motor_up, motor_dn, door_open, req_lamp, state}), 8'(0));
    end
    release_buttons();
    reset = 1'b0;
    tick("reset_release");
    chk("reset_release/state", 8'(state), 8'(0));

    // Same-floor call at floor 0: door only, no motion.
    CLPB = 1'b1;
    tick("samefloor");
    CLPB = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick("samefloor");
      if (door_open) cnt++;
      chk("samefloor/no_motor", 8'(motor_up | motor_dn), 8'(0));
      chk("samefloor/floor", 8'(floor), 8'(0));
    end
    chk("samefloor/door_cycles", 8'(cnt), 8'(DWELL));

    // Upward trip from floor 0.
    CUPB = 1'b1;
    tick("up_k");
    CUPB = 1'b0;
    chk("up_k/lamp", 8'(req_lamp), 8'(2));
    chk("up_k/motor_up", 8'(motor_up), 8'(0));
    for (int i = 0; i < TRAVEL; i++) begin
      tick("up_move");
      chk("up_move/motor_up", 8'(motor_up), 8'(1));
    end
    tick("up_arrive");
    chk("up_arrive/floor", 8'(floor), 8'(1));
    chk("up_arrive/door", 8'(door_open), 8'(1));
    chk("up_arrive/lamp", 8'(req_lamp), 8'(0));
    for (int i = 0; i < DWELL - 1; i++) begin
      tick("up_dwell");
      chk("up_dwell/door", 8'(door_open), 8'(1));
    end
    tick("up_idle");
    chk("up_idle/state", 8'(state), 8'(0));

    // Return to floor 0.
    CLPB = 1'b1;
    tick("return");
    CLPB = 1'b0;
    wait_settled("return");
    chk("return/floor", 8'(floor), 8'(0));

    // Lower-floor call placed during the upward trip.
    CUPB = 1'b1;
    tick("midcall_k");
    CUPB = 1'b0;
    for (int i = 0; i < 5; i++) tick("midcall_move");
    GLPB = 1'b1;
    tick("midcall_press");
    GLPB = 1'b0;
    chk("midcall_press/lamp", 8'(req_lamp), 8'(3));
    cnt = 0;
    while (!door_open && cnt < 40) begin
      tick("midcall_travel");
      cnt++;
    end
    cnt = 0;
    while (door_open && cnt < 40) begin
      chk("midcall_dwell/lamp", 8'(req_lamp), 8'(1));
      chk("midcall_dwell/floor", 8'(floor), 8'(1));
      tick("midcall_dwell");
      cnt++;
    end
    chk("midcall_dwell/cycles", 8'(cnt), 8'(DWELL));
    chk("midcall_gap/state", 8'(state), 8'(0));
    chk("midcall_gap/motor_dn", 8'(motor_dn), 8'(0));
    tick("midcall_down");
    cnt = 0;
    while (motor_dn && cnt < 40) begin
      tick("midcall_down");
      cnt++;
    end
    chk("midcall_down/cycles", 8'(cnt), 8'(TRAVEL));
    chk("midcall_down/floor", 8'(floor), 8'(0));
    chk("midcall_down/lamp", 8'(req_lamp), 8'(0));
    wait_settled("midcall_end");

    // Dwell extension at floor 1: press for floor 1 in the 6th open cycle.
    GUPB = 1'b1;
    tick("ext_call");
    GUPB = 1'b0;
    cnt = 0;
    while (!door_open && cnt < 40) begin
      tick("ext_travel");
      cnt++;
    end
    for (int i = 0; i < 5; i++) tick("ext_open");
    CUPB = 1'b1;
    tick("ext_press");
    CUPB = 1'b0;
    chk("ext_press/lamp", 8'(req_lamp), 8'(0));
    cnt = 6;
    for (int i = 0; i < 50 && door_open; i++) begin
      cnt++;
      tick("ext_hold");
    end
    chk("ext/door_cycles", 8'(cnt), 8'(6 + DWELL));
    wait_settled("ext_end");

    // Back to floor 0, then both floors requested together.
    GLPB = 1'b1;
    tick("prio_return");
    GLPB = 1'b0;
    wait_settled("prio_return");
    GUPB = 1'b1; GLPB = 1'b1;
    tick("prio_press");
    release_buttons();
    chk("prio_press/lamp", 8'(req_lamp), 8'(3));
    tick("prio_first");
    chk("prio_first/door", 8'(door_open), 8'(1));
    chk("prio_first/motor_up", 8'(motor_up), 8'(0));
    chk("prio_first/floor", 8'(floor), 8'(0));
    cnt = 0;
    while (!motor_up && cnt < 40) begin
      tick("prio_wait");
      cnt++;
    end
    chk("prio/motor_up_follows", 8'(motor_up), 8'(1));
    wait_settled("prio_end");

    // Return to floor 0, then reset asynchronously in the 10th MOVE_UP cycle.
    CLPB = 1'b1;
    tick("rst_return");
    CLPB = 1'b0;
    wait_settled("rst_return");
    CUPB = 1'b1;
    tick("rst_k");
    CUPB = 1'b0;
    for (int i = 0; i < 10; i++) tick("rst_move");
    chk("rst_move/motor_up", 8'(motor_up), 8'(1));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_async/motor_up", 8'(motor_up), 8'(0));
    chk("rst_async/floor", 8'(floor), 8'(0));
    chk("rst_async/lamp", 8'(req_lamp), 8'(0));
    chk("rst_async/state", 8'(state), 8'(0));
    tick("rst_hold");
    reset = 1'b0;
    tick("rst_release");

    // Randomized button traffic with one reset pulse in the middle.
    for (int i = 0; i < 1500; i++) begin
      GUPB = ($urandom_range(0, 15) == 0);
      GLPB = ($urandom_range(0, 15) == 0);
      CUPB = ($urandom_range(0, 15) == 0);
      CLPB = ($urandom_range(0, 15) == 0);
      reset = (i == 700 || i == 701);
      tick("random");
    end
    release_buttons();
    reset = 1'b0;
    wait_settled("random_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
